// File: rtl/recv_ctrl_pkg.sv
// rtl/recv_ctrl_pkg.sv - state encoding and frame defaults for the RECV frame sequencer
package recv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  localparam int DEF_FRAME_LEN    = 8860;
  localparam int DEF_PAYLOAD_BITS = 4320;
  localparam int DEF_SIGNAL_BITS  = 24;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/recv_bit_counter.sv
// rtl/recv_bit_counter.sv - saturating bit counter with synchronous clear
module recv_bit_counter #(
  parameter int W     = 13,
  parameter int LIMIT = 4320
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear has priority so a FLUSH cycle always starts the frame from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/recv_frame_ctrl.sv
// rtl/recv_frame_ctrl.sv - per-frame reset/feed/count sequencer in front of RECV
module recv_frame_ctrl
  import recv_ctrl_pkg::*;
#(
  parameter int DW           = 12,
  parameter int FRAME_LEN    = DEF_FRAME_LEN,
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int SIGNAL_BITS  = DEF_SIGNAL_BITS,
  parameter int RST_CYC      = 8,
  parameter int TIMEOUT      = 500000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic          recv_rst,
  output logic [DW-1:0] recv_di_re,
  output logic [DW-1:0] recv_di_im,
  input  logic          recv_sig_vld,
  input  logic          recv_pay_vld,
  output logic          pay_take,
  output logic [4:0]    sig_cnt,
  output logic [12:0]   pay_cnt,
  output logic [15:0]   frame_cnt,
  output logic          frame_done,
  output logic          frame_err,
  output logic          underrun
);

  localparam int CMAX = max_int(max_int(RST_CYC, FRAME_LEN), TIMEOUT);
  localparam int CW   = $clog2(CMAX + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [DW-1:0]   di_re_q, di_re_d, di_im_q, di_im_d;
  logic            underrun_q, underrun_d;
  logic [15:0]     frame_cnt_q;
  logic            count_en, flush, pay_done;

  assign flush    = (state_q == S_FLUSH);
  assign count_en = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign pay_done = (pay_cnt == 13'(PAYLOAD_BITS));

  // One cycle counter serves FLUSH length, FEED slot index and DRAIN timeout;
  // it restarts at zero on every state change.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + CW'(1);
    unique case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (start) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (cyc_q == CW'(RST_CYC - 1)) begin
          state_d = S_FEED;
          cyc_d   = '0;
        end
      end
      S_FEED: begin
        if (cyc_q == CW'(FRAME_LEN - 1)) begin
          state_d = S_DRAIN;
          cyc_d   = '0;
        end
      end
      S_DRAIN: begin
        if (pay_done) begin
          state_d = S_DONE;
          cyc_d   = '0;
        end else if (cyc_q == CW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
          cyc_d   = '0;
        end
      end
      S_DONE, S_ERR: begin
        cyc_d   = '0;
        state_d = start ? S_FLUSH : S_IDLE;
      end
      default: begin
        cyc_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    di_re_d    = '0;
    di_im_d    = '0;
    underrun_d = underrun_q;
    if (flush) begin
      underrun_d = 1'b0;
    end else if (state_q == S_FEED) begin
      if (in_vld) begin
        di_re_d = in_re;
        di_im_d = in_im;
      end else begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      di_re_q     <= '0;
      di_im_q     <= '0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      di_re_q     <= di_re_d;
      di_im_q     <= di_im_d;
      underrun_q  <= underrun_d;
      if (state_q == S_DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  recv_bit_counter #(.W(5), .LIMIT(SIGNAL_BITS)) u_sig_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (flush),
    .inc_i  (count_en & recv_sig_vld),
    .cnt_o  (sig_cnt)
  );

  recv_bit_counter #(.W(13), .LIMIT(PAYLOAD_BITS)) u_pay_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (flush),
    .inc_i  (count_en & recv_pay_vld),
    .cnt_o  (pay_cnt)
  );

  always_comb begin
    busy       = (state_q != S_IDLE);
    in_rdy     = (state_q == S_FEED);
    recv_rst   = (state_q == S_IDLE) || flush;
    frame_done = (state_q == S_DONE);
    frame_err  = (state_q == S_ERR);
    pay_take   = count_en & recv_pay_vld & (pay_cnt < 13'(PAYLOAD_BITS));
    recv_di_re = di_re_q;
    recv_di_im = di_im_q;
    underrun   = underrun_q;
    frame_cnt  = frame_cnt_q;
  end

endmodule

// File: tb/tb_recv_frame_ctrl.sv
// tb/tb_recv_frame_ctrl.sv - directed self-checking bench for recv_frame_ctrl
module tb_recv_frame_ctrl;

  localparam int DW = 12;
  localparam int FL = 64;
  localparam int PB = 32;
  localparam int SB = 24;
  localparam int RC = 8;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst, start, busy, in_vld, in_rdy, recv_rst;
  logic [DW-1:0] in_re, in_im, recv_di_re, recv_di_im;
  logic          recv_sig_vld, recv_pay_vld, pay_take;
  logic [4:0]    sig_cnt;
  logic [12:0]   pay_cnt;
  logic [15:0]   frame_cnt;
  logic          frame_done, frame_err, underrun;

  int n_vec = 0;
  int n_bad = 0;
  int n_rst = 0, n_done = 0, n_err = 0, n_take = 0, n_feed = 0, n_idle = 0;

  recv_frame_ctrl #(
    .DW(DW), .FRAME_LEN(FL), .PAYLOAD_BITS(PB), .SIGNAL_BITS(SB),
    .RST_CYC(RC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_re(in_re), .in_im(in_im), .in_vld(in_vld), .in_rdy(in_rdy),
    .recv_rst(recv_rst), .recv_di_re(recv_di_re), .recv_di_im(recv_di_im),
    .recv_sig_vld(recv_sig_vld), .recv_pay_vld(recv_pay_vld), .pay_take(pay_take),
    .sig_cnt(sig_cnt), .pay_cnt(pay_cnt), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .frame_err(frame_err), .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (busy && recv_rst) n_rst++;
      if (frame_done) n_done++;
      if (frame_err) n_err++;
      if (pay_take) n_take++;
      if (in_rdy) n_feed++;
      if (!busy) n_idle++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Drives FL slots once FEED is reached; slots [gap_lo, gap_lo+gap_n) have in_vld=0.
  task automatic feed_frame(input int n_pay, input int gap_lo, input int gap_n);
    int w;
    int bad;
    logic vld;
    w = 0;
    bad = 0;
    while (!in_rdy && w < 50) begin
      step();
      w++;
    end
    chk("feed_reached", in_rdy, 1);
    for (int k = 0; k < FL; k++) begin
      vld = !(k >= gap_lo && k < gap_lo + gap_n);
      if (!in_rdy) bad++;
      in_vld       = vld;
      in_re        = DW'(k);
      in_im        = DW'(3 * k + 1);
      recv_pay_vld = (k < n_pay);
      recv_sig_vld = 1'b1;
      step();
      if (recv_di_re !== (vld ? DW'(k) : '0)) bad++;
      if (recv_di_im !== (vld ? DW'(3 * k + 1) : '0)) bad++;
    end
    in_vld       = 1'b0;
    recv_pay_vld = 1'b0;
    recv_sig_vld = 1'b0;
    chk("feed_slots", bad, 0);
    chk("feed_end_rdy", in_rdy, 0);
  endtask

  task automatic pay_burst(input int n);
    recv_pay_vld = 1'b1;
    for (int i = 0; i < n; i++) step();
    recv_pay_vld = 1'b0;
  endtask

  task automatic wait_end(input int bound, output int steps);
    steps = 0;
    while (!(frame_done || frame_err) && steps < bound) begin
      step();
      steps++;
    end
    chk("end_seen", frame_done | frame_err, 1);
  endtask

  initial begin
    int s, s_rst, s_done, s_err, s_take, s_feed, s_idle;
    rst = 1'b0; start = 1'b0; in_vld = 1'b0; in_re = '0; in_im = '0;
    recv_sig_vld = 1'b0; recv_pay_vld = 1'b0;
    step();
    step();
    chk("rst_recv_rst", recv_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_pay_cnt", pay_cnt, 0);
    rst = 1'b1;
    step();

    recv_pay_vld = 1'b1;
    recv_sig_vld = 1'b1;
    step(); step(); step();
    chk("idle_pay_take", pay_take, 0);
    chk("idle_pay_cnt", pay_cnt, 0);
    chk("idle_sig_cnt", sig_cnt, 0);
    recv_pay_vld = 1'b0;
    recv_sig_vld = 1'b0;

    // single frame, payload arriving in DRAIN
    s_rst = n_rst; s_done = n_done; s_feed = n_feed;
    pulse_start();
    chk("t1_busy", busy, 1);
    feed_frame(0, FL, 0);
    pay_burst(PB);
    chk("t1_pay_cnt", pay_cnt, PB);
    wait_end(10, s);
    chk("t1_done_lat", s, 1);
    step();
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_idle", busy, 0);
    chk("t1_sig_sat", sig_cnt, SB);
    chk("t1_rst_cycles", n_rst - s_rst, RC);
    chk("t1_done_pulses", n_done - s_done, 1);
    chk("t1_feed_cycles", n_feed - s_feed, FL);

    // three back-to-back frames with start held
    s_rst = n_rst; s_done = n_done;
    start = 1'b1;
    step();
    s_idle = n_idle;
    for (int f = 0; f < 3; f++) begin
      feed_frame(0, FL, 0);
      pay_burst(PB);
      wait_end(10, s);
      if (f == 2) start = 1'b0;
    end
    chk("t2_no_idle", n_idle - s_idle, 0);
    step();
    chk("t2_frame_cnt", frame_cnt, 4);
    chk("t2_done_pulses", n_done - s_done, 3);
    chk("t2_rst_cycles", n_rst - s_rst, 3 * RC);

    // timeout with short payload
    s_done = n_done; s_err = n_err;
    pulse_start();
    feed_frame(0, FL, 0);
    pay_burst(PB - 2);
    wait_end(200, s);
    chk("t3_err", frame_err, 1);
    chk("t3_drain_len", 30 + s, TO);
    chk("t3_pay_cnt", pay_cnt, PB - 2);
    step();
    chk("t3_frame_cnt", frame_cnt, 4);
    chk("t3_err_pulses", n_err - s_err, 1);
    chk("t3_done_pulses", n_done - s_done, 0);

    // excess payload during FEED
    s_take = n_take; s_feed = n_feed;
    pulse_start();
    feed_frame(PB + 10, FL, 0);
    chk("t4_pay_cnt", pay_cnt, PB);
    chk("t4_take", n_take - s_take, PB);
    chk("t4_feed_cycles", n_feed - s_feed, FL);
    chk("t4_drain_first", frame_done, 0);
    step();
    chk("t4_done", frame_done, 1);
    step();
    chk("t4_frame_cnt", frame_cnt, 5);

    // underrun gap of 5 slots
    s_feed = n_feed;
    pulse_start();
    feed_frame(PB, 10, 5);
    chk("t5_underrun", underrun, 1);
    chk("t5_feed_cycles", n_feed - s_feed, FL);
    step();
    step();
    chk("t5_sticky", underrun, 1);
    chk("t5_frame_cnt", frame_cnt, 6);

    // async reset mid-FEED
    pulse_start();
    step();
    chk("t6_flush_clr", underrun, 0);
    s = 0;
    while (!in_rdy && s < 50) begin
      step();
      s++;
    end
    in_vld = 1'b1; recv_pay_vld = 1'b1; recv_sig_vld = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("t6_pre_pay_cnt", pay_cnt, 20);
    s_done = n_done; s_err = n_err;
    rst = 1'b0;
    #1;
    chk("t6_recv_rst", recv_rst, 1);
    chk("t6_in_rdy", in_rdy, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pay_cnt", pay_cnt, 0);
    chk("t6_sig_cnt", sig_cnt, 0);
    chk("t6_frame_cnt", frame_cnt, 0);
    chk("t6_recv_di", recv_di_re, 0);
    chk("t6_pay_take", pay_take, 0);
    step(); step();
    rst = 1'b1;
    in_vld = 1'b0; recv_pay_vld = 1'b0; recv_sig_vld = 1'b0;
    step(); step(); step();
    chk("t6_no_pulse", (n_done - s_done) + (n_err - s_err), 0);
    chk("t6_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
